memory_arbiter: RTL

//  Shares the single RAM port between the instruction-fetch requester (iREN) and the

---
 rtl/memory_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access: data has
// priority, instruction fetch is protected from starvation, stalled RAM accesses abort.
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        ram_ready,
  input  logic [31:0] ram_load,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TIMER_LIM  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  timer_q, timer_d;
  logic        berr_q, berr_d;

  logic        dreq;
  logic        served_req;
  logic        done_ok;
  logic        timed_out;
  logic        finish;

  // Request of whichever side currently owns the RAM; a drop here is a withdrawal.
  always_comb begin
    dreq       = dREN | dWEN;
    served_req = 1'b0;
    case (state_q)
      SERVE_I: served_req = iREN;
      SERVE_D: served_req = dreq;
      default: served_req = 1'b0;
    endcase
    done_ok   = served_req & ram_ready;
    timed_out = served_req & ~ram_ready & (timer_q == TIMER_LIM);
    finish    = done_ok | timed_out;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iREN && (!dreq || streak_q == STREAK_LIM)) begin
          state_d = SERVE_I;
        end else if (dreq) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (!served_req || finish) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM side follows the live requester inputs so a withdrawal drops enables at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = dreq;
    iload    = '0;
    dload    = '0;
    case (state_q)
      SERVE_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = iREN & ~finish;
        iload   = done_ok ? ram_load : '0;
      end
      SERVE_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = dreq & ~finish;
        dload    = done_ok ? ram_load : '0;
      end
      default: ;
    endcase
  end

  // Streak counts data completions that overtook a pending fetch; timer bounds a SERVE.
  always_comb begin
    streak_d = streak_q;
    if (!iREN) begin
      streak_d = '0;
    end else if (state_q == SERVE_I && done_ok) begin
      streak_d = '0;
    end else if (state_q == SERVE_D && done_ok && streak_q < STREAK_LIM) begin
      streak_d = streak_q + 4'd1;
    end

    timer_d = timer_q;
    if (state_q == IDLE) begin
      timer_d = '0;
    end else if (!ram_ready && !finish) begin
      timer_d = timer_q + 8'd1;
    end

    berr_d = berr_q | timed_out;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak_q <= '0;
      timer_q  <= '0;
      berr_q   <= 1'b0;
    end else begin
      streak_q <= streak_d;
      timer_q  <= timer_d;
      berr_q   <= berr_d;
    end
  end

  assign bus_err = berr_q;

endmodule
